// File: rtl/mouse_packet_receiver.sv
// rtl/mouse_packet_receiver.sv - PS/2 mouse frame/packet receiver, emits {8'h00, status, X, Y} per 3-byte packet
// Define MOUSE_PARITY_CHECK_EN to reject bytes failing odd parity; SYNC_STAGES must be >= 2.
module mouse_packet_receiver #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [31:0] MouseData,
    output logic        MouseEnable,
    output logic        FrameError
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s, bit_in, fall, timeout;
    logic [TW-1:0]          timer;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg, status_q, x_q;
    logic [1:0]             pkt_idx;
    logic                   parity_bad;
    logic                   byte_ok, frame_err_c, pkt_done_c, idx_clear;

    assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
    assign bit_in    = data_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~ps2_clk_s;
    assign timeout   = !fall && (timer == TO_LIMIT);

    // Synchronisers reset to 1 so a released reset never looks like a falling edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev  <= ps2_clk_s;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            timer <= '0;
        else if (fall || timeout)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end

`ifdef MOUSE_PARITY_CHECK_EN
    logic parity_bit;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            parity_bit <= 1'b0;
        else if (fall && state == PARITY)
            parity_bit <= bit_in;
    end

    assign parity_bad = ~(^{shift_reg, parity_bit});
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!bit_in) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Byte disposition is decided at the stop-bit edge; strobes are registered one cycle later
    always_comb begin
        byte_ok     = 1'b0;
        frame_err_c = 1'b0;
        pkt_done_c  = 1'b0;
        idx_clear   = 1'b0;
        if (timeout) begin
            idx_clear   = 1'b1;
            frame_err_c = (state != IDLE);
        end else if (fall && state == STOP) begin
            if (parity_bad) begin
                frame_err_c = 1'b1;
                idx_clear   = 1'b1;
            end else if (!bit_in) begin
                frame_err_c = 1'b1;
            end else if (pkt_idx == 2'd0 && !shift_reg[3]) begin
                frame_err_c = 1'b1;
            end else begin
                byte_ok    = 1'b1;
                pkt_done_c = (pkt_idx == 2'd2);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            pkt_idx     <= 2'd0;
            status_q    <= 8'h00;
            x_q         <= 8'h00;
            MouseData   <= 32'h0;
            MouseEnable <= 1'b0;
            FrameError  <= 1'b0;
        end else begin
            MouseEnable <= pkt_done_c;
            FrameError  <= frame_err_c;
            if (fall && state == IDLE && !bit_in)
                bit_cnt <= 3'd0;
            if (fall && state == DATA) begin
                shift_reg <= {bit_in, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (idx_clear) begin
                pkt_idx <= 2'd0;
            end else if (byte_ok) begin
                case (pkt_idx)
                    2'd0: begin
                        status_q <= shift_reg;
                        pkt_idx  <= 2'd1;
                    end
                    2'd1: begin
                        x_q     <= shift_reg;
                        pkt_idx <= 2'd2;
                    end
                    default: begin
                        MouseData <= {8'h00, status_q, x_q, shift_reg};
                        pkt_idx   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mouse_packet_receiver.sv
// tb/tb_mouse_packet_receiver.sv - directed self-checking bench for mouse_packet_receiver
module tb_mouse_packet_receiver;

    localparam int TO   = 200;
    localparam int HALF = 10;
    localparam int GAP  = 20;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DATA = 1'b1;
    logic [31:0] MouseData;
    logic        MouseEnable;
    logic        FrameError;

    int total = 0;
    int bad = 0;
    int en_cnt = 0, fe_cnt = 0, both_cnt = 0, long_cnt = 0;
    logic en_prev = 1'b0, fe_prev = 1'b0;

    mouse_packet_receiver #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PS2_CLK(PS2_CLK),
        .PS2_DATA(PS2_DATA),
        .MouseData(MouseData),
        .MouseEnable(MouseEnable),
        .FrameError(FrameError)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (MouseEnable) en_cnt++;
        if (FrameError) fe_cnt++;
        if (MouseEnable && FrameError) both_cnt++;
        if ((MouseEnable && en_prev) || (FrameError && fe_prev)) long_cnt++;
        en_prev = MouseEnable;
        fe_prev = FrameError;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par, input bit lat);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(posedge CLK); #1 PS2_DATA = bits[i];
            repeat (HALF) @(posedge CLK);
            #1 PS2_CLK = 1'b0;
            if (lat && i == 10) begin
                repeat (2) @(posedge CLK); #1;
                total++;
                if (MouseEnable !== 1'b0) begin
                    bad++; $display("FAIL latency_early: MouseEnable=%b want 0", MouseEnable);
                end
                @(posedge CLK); #1;
                total++;
                if (MouseEnable !== 1'b1) begin
                    bad++; $display("FAIL latency_strobe: MouseEnable=%b want 1", MouseEnable);
                end
                repeat (HALF - 3) @(posedge CLK);
            end else begin
                repeat (HALF) @(posedge CLK);
            end
            #1 PS2_CLK = 1'b1;
        end
        @(posedge CLK); #1 PS2_DATA = 1'b1;
        repeat (GAP) @(posedge CLK);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            @(posedge CLK); #1 PS2_DATA = bits[i];
            repeat (HALF) @(posedge CLK);
            #1 PS2_CLK = 1'b0;
            repeat (HALF) @(posedge CLK);
            #1 PS2_CLK = 1'b1;
        end
        @(posedge CLK); #1 PS2_DATA = 1'b1;
    endtask

    task automatic send_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        send_frame(s, 1'b1, 1'b0, 1'b0);
        send_frame(x, 1'b1, 1'b0, 1'b0);
        send_frame(y, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(posedge CLK); #1;
        total++;
        if (MouseData !== 32'h0) begin
            bad++; $display("FAIL reset_data: MouseData=%h want 00000000", MouseData);
        end
        total++;
        if (MouseEnable !== 1'b0 || FrameError !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: en=%b fe=%b want 0 0", MouseEnable, FrameError);
        end
        RESET = 1'b0;
        repeat (5) @(posedge CLK); #1;
        total++;
        if (MouseEnable !== 1'b0 || FrameError !== 1'b0) begin
            bad++; $display("FAIL post_reset_strobes: en=%b fe=%b want 0 0", MouseEnable, FrameError);
        end
    endtask

    task automatic test_basic;
        int e0, f0;
        e0 = en_cnt; f0 = fe_cnt;
        send_frame(8'h08, 1'b1, 1'b0, 1'b0);
        send_frame(8'h05, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFB, 1'b1, 1'b0, 1'b1);
        total++;
        if (MouseData !== 32'h000805FB) begin
            bad++; $display("FAIL basic_data: MouseData=%h want 000805fb", MouseData);
        end
        total++;
        if (en_cnt - e0 != 1) begin
            bad++; $display("FAIL basic_enables: got %0d want 1", en_cnt - e0);
        end
        total++;
        if (fe_cnt - f0 != 0) begin
            bad++; $display("FAIL basic_errors: got %0d want 0", fe_cnt - f0);
        end
    endtask

    task automatic test_realign;
        int e0, f0;
        e0 = en_cnt; f0 = fe_cnt;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        total++;
        if (fe_cnt - f0 != 1) begin
            bad++; $display("FAIL realign_error: got %0d want 1", fe_cnt - f0);
        end
        send_packet(8'h09, 8'h10, 8'h20);
        total++;
        if (MouseData !== 32'h00091020) begin
            bad++; $display("FAIL realign_data: MouseData=%h want 00091020", MouseData);
        end
        total++;
        if (en_cnt - e0 != 1 || fe_cnt - f0 != 1) begin
            bad++; $display("FAIL realign_counts: en=%0d fe=%0d want 1 1", en_cnt - e0, fe_cnt - f0);
        end
    endtask

    task automatic test_stop_error;
        int e0, f0;
        e0 = en_cnt; f0 = fe_cnt;
        send_frame(8'h08, 1'b0, 1'b0, 1'b0);
        total++;
        if (fe_cnt - f0 != 1 || en_cnt - e0 != 0) begin
            bad++; $display("FAIL stop_error_counts: en=%0d fe=%0d want 0 1", en_cnt - e0, fe_cnt - f0);
        end
        total++;
        if (MouseData !== 32'h00091020) begin
            bad++; $display("FAIL stop_error_hold: MouseData=%h want 00091020", MouseData);
        end
        send_packet(8'h08, 8'h05, 8'hFB);
        total++;
        if (MouseData !== 32'h000805FB || en_cnt - e0 != 1) begin
            bad++; $display("FAIL stop_error_recover: MouseData=%h en=%0d want 000805fb 1", MouseData, en_cnt - e0);
        end
    endtask

    task automatic test_data_hold;
        int e0;
        e0 = en_cnt;
        send_frame(8'h08, 1'b1, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0);
        total++;
        if (MouseData !== 32'h000805FB || en_cnt - e0 != 0) begin
            bad++; $display("FAIL hold_partial: MouseData=%h en=%0d want 000805fb 0", MouseData, en_cnt - e0);
        end
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        total++;
        if (MouseData !== 32'h00084455 || en_cnt - e0 != 1) begin
            bad++; $display("FAIL hold_complete: MouseData=%h en=%0d want 00084455 1", MouseData, en_cnt - e0);
        end
    endtask

    task automatic test_idle_timeout;
        int e0, f0;
        e0 = en_cnt; f0 = fe_cnt;
        send_frame(8'h08, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        repeat (2 * TO) @(posedge CLK);
        total++;
        if (fe_cnt - f0 != 0 || en_cnt - e0 != 0) begin
            bad++; $display("FAIL idle_timeout_quiet: en=%0d fe=%0d want 0 0", en_cnt - e0, fe_cnt - f0);
        end
        send_packet(8'h18, 8'h02, 8'h03);
        total++;
        if (MouseData !== 32'h00180203 || en_cnt - e0 != 1) begin
            bad++; $display("FAIL idle_timeout_data: MouseData=%h en=%0d want 00180203 1", MouseData, en_cnt - e0);
        end
    endtask

    task automatic test_frame_timeout;
        int e0, f0;
        e0 = en_cnt; f0 = fe_cnt;
        send_partial(8'h33, 3);
        repeat (2 * TO) @(posedge CLK);
        total++;
        if (fe_cnt - f0 != 1 || en_cnt - e0 != 0) begin
            bad++; $display("FAIL frame_timeout_counts: en=%0d fe=%0d want 0 1", en_cnt - e0, fe_cnt - f0);
        end
        send_packet(8'h18, 8'h22, 8'h33);
        total++;
        if (MouseData !== 32'h00182233) begin
            bad++; $display("FAIL frame_timeout_data: MouseData=%h want 00182233", MouseData);
        end
    endtask

    task automatic test_parity;
        int e0, f0;
        e0 = en_cnt; f0 = fe_cnt;
        send_frame(8'h08, 1'b1, 1'b0, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFB, 1'b1, 1'b0, 1'b0);
`ifdef MOUSE_PARITY_CHECK_EN
        total++;
        if (fe_cnt - f0 != 1 || en_cnt - e0 != 0) begin
            bad++; $display("FAIL parity_counts: en=%0d fe=%0d want 0 1", en_cnt - e0, fe_cnt - f0);
        end
        total++;
        if (MouseData !== 32'h00182233) begin
            bad++; $display("FAIL parity_hold: MouseData=%h want 00182233", MouseData);
        end
`else
        total++;
        if (fe_cnt - f0 != 0 || en_cnt - e0 != 1) begin
            bad++; $display("FAIL parity_counts: en=%0d fe=%0d want 1 0", en_cnt - e0, fe_cnt - f0);
        end
        total++;
        if (MouseData !== 32'h000805FB) begin
            bad++; $display("FAIL parity_ignored: MouseData=%h want 000805fb", MouseData);
        end
`endif
        repeat (2 * TO) @(posedge CLK);
    endtask

    task automatic test_reset_mid_frame;
        int e0, f0;
        send_frame(8'h08, 1'b1, 1'b0, 1'b0);
        send_partial(8'h7F, 4);
        @(posedge CLK); #1 RESET = 1'b1;
        #1;
        total++;
        if (MouseData !== 32'h0 || MouseEnable !== 1'b0 || FrameError !== 1'b0) begin
            bad++; $display("FAIL reset_async: MouseData=%h en=%b fe=%b want 00000000 0 0", MouseData, MouseEnable, FrameError);
        end
        repeat (3) @(posedge CLK); #1 RESET = 1'b0;
        repeat (3) @(posedge CLK);
        e0 = en_cnt; f0 = fe_cnt;
        send_packet(8'h08, 8'h7F, 8'h80);
        total++;
        if (MouseData !== 32'h00087F80) begin
            bad++; $display("FAIL reset_recover_data: MouseData=%h want 00087f80", MouseData);
        end
        total++;
        if (en_cnt - e0 != 1 || fe_cnt - f0 != 0) begin
            bad++; $display("FAIL reset_recover_counts: en=%0d fe=%0d want 1 0", en_cnt - e0, fe_cnt - f0);
        end
    endtask

    task automatic test_strobe_rules;
        total++;
        if (both_cnt != 0) begin
            bad++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt);
        end
        total++;
        if (long_cnt != 0) begin
            bad++; $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", long_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_realign();
        test_stop_error();
        test_data_hold();
        test_idle_timeout();
        test_frame_timeout();
        test_parity();
        test_reset_mid_frame();
        test_strobe_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mouse_packet_receiver.md
MOUSE_PACKET_RECEIVER -- requirements
Module: mouse_packet_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, CLK cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops synchronising PS2_CLK and PS2_DATA.
REQ-003 SHALL have port CLK  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PS2_CLK  input  1  mouse clock, asynchronous to CLK.
REQ-006 SHALL have port PS2_DATA  input  1  mouse data, asynchronous to CLK.
REQ-007 SHALL have port MouseData  output  32  last complete packet: {8'h00, status, X, Y}.
REQ-008 SHALL have port MouseEnable  output  1  one-CLK-cycle strobe, MouseData valid and new.
REQ-009 SHALL have port FrameError  output  1  one-CLK-cycle strobe on discarded frame.

Function
REQ-010 SHALL pass PS2_CLK and PS2_DATA through SYNC_STAGES flip-flops; sample data only on a synchronised PS2_CLK falling edge (1->0).
REQ-011 SHALL implement frame FSM states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: falling edge with data 0 -> DATA, bit count cleared; falling edge with data 1 -> stay IDLE, no error.
REQ-013 DATA: shift 8 bits LSB first, one per falling edge; after the 8th -> PARITY.
REQ-014 PARITY: capture parity bit -> STOP.
REQ-015 STOP: data 1 -> byte accepted, return IDLE; data 0 -> FrameError strobe, byte discarded, IDLE.
REQ-016 SHALL keep packet byte index 0..2; accepted byte stored as status (0), X (1), Y (2); index wraps 2 -> 0.
REQ-017 Byte at index 0 with bit 3 = 0 SHALL be discarded (FrameError strobe, index stays 0) to realign packets.
REQ-018 On acceptance of byte index 2, MouseData SHALL update and MouseEnable SHALL assert for exactly one cycle, both on the CLK edge after the stop-bit falling edge is detected (synchroniser delay plus 1 cycle).
REQ-019 MouseData SHALL hold its value between packets; bytes 0 and 1 SHALL NOT alter MouseData.
REQ-020 Timeout counter SHALL clear on every falling edge; in any state other than IDLE, reaching TIMEOUT_CYCLES SHALL force IDLE, clear packet index to 0, strobe FrameError.
REQ-021 In IDLE, timeout SHALL clear packet index to 0 without FrameError.
REQ-022 MouseEnable and FrameError SHALL never assert in the same cycle; a frame error at index 2 SHALL NOT produce MouseEnable.

Reset
REQ-023 RESET high SHALL immediately force: FSM IDLE, bit count 0, packet index 0, timeout counter 0, synchronisers to 1 (idle bus), MouseData 32'h0, MouseEnable 0, FrameError 0.
REQ-024 Reset mid-frame SHALL discard the partial frame and partial packet; first frame after release starts at index 0.

Configuration
REQ-025 With macro MOUSE_PARITY_CHECK_EN defined, STOP SHALL additionally require odd parity over 8 data bits plus parity bit; mismatch -> FrameError, byte discarded, packet index reset to 0.
REQ-026 Without MOUSE_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored.

Verification
REQ-027 Packets 0x08, 0x05, 0xFB with correct parity/stop -> one MouseEnable pulse, MouseData = 32'h000805FB, FrameError never asserts.
REQ-028 Byte 0x00 (bit3 = 0) then 0x09, 0x10, 0x20 -> one FrameError on first byte, then MouseData = 32'h00091020 with one MouseEnable.
REQ-029 Byte 0x08 sent with stop bit 0 -> FrameError pulse, no MouseEnable, next valid 3-byte packet decodes correctly.
REQ-030 0x08, 0x01 then bus idle > TIMEOUT_CYCLES -> index reset; following 0x18, 0x02, 0x03 -> MouseData = 32'h00180203.
REQ-031 With MOUSE_PARITY_CHECK_EN, X byte 0x05 sent with even parity -> FrameError, no MouseEnable; without the macro -> MouseData = 32'h000805FB.
REQ-032 RESET asserted after 4 data bits of byte 1 -> outputs zero immediately; after release a full packet 0x08, 0x7F, 0x80 -> MouseData = 32'h00087F80.
